// File: rtl/ula_fdiv_seq.sv
// ula_fdiv_seq: multi-cycle divider for the custom float format
// {s, e (two's complement), m (integer mantissa, no hidden bit)}, value = (-1)^s * m * 2^e.
// Both operands are pre-normalized (mantissa MSB set). A restoring division then
// produces one quotient bit per cycle, and the result is renormalized and truncated.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; zero-divisor and zero-dividend answers are produced here
// NORM  | shift each mantissa left until its MSB is set, adjusting its exponent
// DIV   | restoring division, MAN+1 quotient bits, MSB first
// FIX   | pick the quotient window, compute the exponent, publish the result
module ula_fdiv_seq #(
  parameter int NBMANT = 23,
  parameter int NBEXPO = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NBMANT+NBEXPO:0]   in1,
  input  logic [NBMANT+NBEXPO:0]   in2,
  output logic [NBMANT+NBEXPO:0]   out,
  output logic                     busy,
  output logic                     done,
  output logic                     dbz
);

  localparam int MAN = NBMANT;
  localparam int EXP = NBEXPO;
  localparam int W   = MAN + EXP + 1;
  localparam int CW  = $clog2(MAN + 1);

  // Exponent arithmetic runs in EXP+2 bits so normalization shifts and the
  // difference of two exponents cannot overflow before the final truncation.
  localparam logic [EXP+1:0] MAN_E = (EXP+2)'(MAN);

  typedef enum logic [1:0] {IDLE, NORM, DIV, FIX} state_t;

  state_t          state, state_n;
  logic            sgn, sgn_n;
  logic [MAN-1:0]  m1, m1_n, m2, m2_n;
  logic [EXP+1:0]  e1, e1_n, e2, e2_n;
  logic [MAN:0]    rem, rem_n;
  logic [MAN:0]    q, q_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [W-1:0]    out_r, out_n;
  logic            done_r, done_n;
  logic            dbz_r, dbz_n;

  logic            in_sgn;
  logic [EXP+1:0]  e_adj;
  logic [EXP-1:0]  fix_exp;
  logic [MAN-1:0]  fix_mant;

  assign in_sgn   = in1[W-1] ^ in2[W-1];

  // The quotient lies in (2^(MAN-1), 2^(MAN+1)); when its top bit is set we
  // keep the upper MAN bits and bump the exponent by one to compensate.
  assign e_adj    = {{(EXP+1){1'b0}}, q[MAN]};
  assign fix_exp  = EXP'(e1 - e2 - MAN_E + e_adj);
  assign fix_mant = q[MAN] ? q[MAN:1] : q[MAN-1:0];

  assign out  = out_r;
  assign done = done_r;
  assign dbz  = dbz_r;
  assign busy = (state != IDLE);

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sgn    <= 1'b0;
      m1     <= '0;
      m2     <= '0;
      e1     <= '0;
      e2     <= '0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      out_r  <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      state  <= state_n;
      sgn    <= sgn_n;
      m1     <= m1_n;
      m2     <= m2_n;
      e1     <= e1_n;
      e2     <= e2_n;
      rem    <= rem_n;
      q      <= q_n;
      cnt    <= cnt_n;
      out_r  <= out_n;
      done_r <= done_n;
      dbz_r  <= dbz_n;
    end
  end

  // Next-state and datapath update; everything holds unless a state changes it.
  always_comb begin
    state_n = state;
    sgn_n   = sgn;
    m1_n    = m1;
    m2_n    = m2;
    e1_n    = e1;
    e2_n    = e2;
    rem_n   = rem;
    q_n     = q;
    cnt_n   = cnt;
    out_n   = out_r;
    done_n  = 1'b0;
    dbz_n   = dbz_r;

    case (state)
      IDLE: begin
        if (start) begin
          sgn_n = in_sgn;
          m1_n  = in1[MAN-1:0];
          m2_n  = in2[MAN-1:0];
          e1_n  = {{2{in1[W-2]}}, in1[W-2:MAN]};
          e2_n  = {{2{in2[W-2]}}, in2[W-2:MAN]};
          // A zero divisor wins over a zero dividend.
          if (in2[MAN-1:0] == '0) begin
            out_n  = {in_sgn, 1'b0, {(EXP-1){1'b1}}, {MAN{1'b1}}};
            done_n = 1'b1;
            dbz_n  = 1'b1;
          end else if (in1[MAN-1:0] == '0) begin
            out_n  = '0;
            done_n = 1'b1;
            dbz_n  = 1'b0;
          end else begin
            state_n = NORM;
          end
        end
      end

      NORM: begin
        if (m1[MAN-1] && m2[MAN-1]) begin
          rem_n   = {1'b0, m1};
          q_n     = '0;
          cnt_n   = CW'(MAN);
          state_n = DIV;
        end else begin
          if (!m1[MAN-1]) begin
            m1_n = m1 << 1;
            e1_n = e1 - 1'b1;
          end
          if (!m2[MAN-1]) begin
            m2_n = m2 << 1;
            e2_n = e2 - 1'b1;
          end
        end
      end

      DIV: begin
        // With both operands normalized the partial remainder stays below
        // 2*m2, so MAN+1 bits always hold it.
        if (rem >= {1'b0, m2}) begin
          rem_n = (rem - {1'b0, m2}) << 1;
          q_n   = {q[MAN-1:0], 1'b1};
        end else begin
          rem_n = rem << 1;
          q_n   = {q[MAN-1:0], 1'b0};
        end
        if (cnt == '0) begin
          state_n = FIX;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      FIX: begin
        out_n   = {sgn, fix_exp, fix_mant};
        done_n  = 1'b1;
        dbz_n   = 1'b0;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ula_fdiv_seq.sv
// Bench for ula_fdiv_seq: directed cases plus randomized operands checked
// against a value-level reference model of the float division.
module tb_ula_fdiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] out;
  logic        busy;
  logic        done;
  logic        dbz;

  int n_cmp = 0;
  int n_err = 0;

  ula_fdiv_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: normalize by value, divide with wide integers, pick the window.
  // Latency is counted in edges after the start edge until done is visible.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o, output logic dz, output int lat);
    longint m1, m2, q, mant;
    int     e1, e2, e, sh1, sh2;
    logic   s;
    s   = a[31] ^ b[31];
    m1  = longint'(a[22:0]);
    m2  = longint'(b[22:0]);
    e1  = int'($signed(a[30:23]));
    e2  = int'($signed(b[30:23]));
    sh1 = 0;
    sh2 = 0;
    if (m2 == 0) begin
      o = {s, 8'h7F, 23'h7FFFFF}; dz = 1'b1; lat = 0;
    end else if (m1 == 0) begin
      o = 32'h0; dz = 1'b0; lat = 0;
    end else begin
      while (m1 < 64'd4194304) begin m1 = m1 * 2; e1 = e1 - 1; sh1++; end
      while (m2 < 64'd4194304) begin m2 = m2 * 2; e2 = e2 - 1; sh2++; end
      q = (m1 * 64'd8388608) / m2;
      if (q >= 64'd8388608) begin
        mant = q / 2;
        e    = e1 - e2 - 22;
      end else begin
        mant = q;
        e    = e1 - e2 - 23;
      end
      o   = {s, 8'(e), 23'(mant)};
      dz  = 1'b0;
      lat = 26 + ((sh1 > sh2) ? sh1 : sh2);
    end
  endfunction

  // Issue one operation, scramble inputs after the start edge, wait for done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp_o;
    logic        exp_dz;
    int          exp_lat;
    int          lat;
    logic        busy_bad;
    model(a, b, exp_o, exp_dz, exp_lat);
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in1 = $urandom; in2 = $urandom;
    lat = 0;
    busy_bad = 1'b0;
    while (!done && lat < 200) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({31'd0, done}, 32'd1, {tag, "_done_seen"});
    check(out, exp_o, {tag, "_out"});
    check({31'd0, dbz}, {31'd0, exp_dz}, {tag, "_dbz"});
    check(32'(lat), 32'(exp_lat), {tag, "_latency"});
    check({31'd0, busy_bad}, 32'd0, {tag, "_busy_during"});
    check({31'd0, busy}, 32'd0, {tag, "_busy_after"});
    @(posedge clk); #1;
    check({31'd0, done}, 32'd0, {tag, "_done_pulse"});
    check(out, exp_o, {tag, "_out_hold"});
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [22:0] rm;
    int          lat;

    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check(out, 32'h0, "reset_out");
    check({29'd0, busy, done, dbz}, 32'h0, "reset_flags");
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h75400000, 32'h75400000, "one_div_one");
    check(out, 32'h75400000, "one_div_one_const");
    run_op(32'h75E00000, 32'h75C00000, "three_div_two");
    check(out, 32'h75600000, "three_div_two_const");
    run_op(32'hF5400000, 32'h75E00000, "neg_one_div_three");
    check(out, 32'hF4555555, "neg_one_div_three_const");
    run_op(32'h00000001, 32'h75400000, "unnorm_dividend");
    check(out, 32'h75400000, "unnorm_dividend_const");
    run_op(32'h75400000, 32'h00000000, "div_by_zero");
    check(out, 32'h3FFFFFFF, "div_by_zero_const");
    run_op(32'h00000000, 32'h75400000, "zero_dividend");
    run_op(32'h00000000, 32'h80000000, "zero_by_zero");
    run_op(32'h75400000, 32'h00000001, "unnorm_divisor");

    // Start pulsed again in cycle 5 must be ignored.
    @(negedge clk);
    in1 = 32'h75400000; in2 = 32'h75400000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (4) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    in1 = 32'h75E00000; in2 = 32'h75C00000; start = 1'b1;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
    check(out, 32'h75400000, "restart_ignored_out");
    check(32'(lat), 32'd26, "restart_ignored_latency");

    // Reset in the middle of an operation clears everything at once.
    @(negedge clk);
    in1 = 32'h75E00000; in2 = 32'h75C00000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check({31'd0, busy}, 32'd1, "pre_reset_busy");
    rst = 1'b1;
    #1;
    check(out, 32'h0, "midop_reset_out");
    check({29'd0, busy, done, dbz}, 32'h0, "midop_reset_flags");
    @(posedge clk); #1;
    check({29'd0, busy, done, dbz}, 32'h0, "midop_reset_held");
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h75E00000, 32'h75C00000, "after_reset");

    // Randomized operands, including unnormalized and zero mantissas.
    for (int i = 0; i < 40; i++) begin
      rm = 23'($urandom);
      rm = rm >> $urandom_range(0, 22);
      if ($urandom_range(0, 15) == 0) rm = '0;
      ra = {1'($urandom), 8'($urandom), rm};
      rm = 23'($urandom);
      rm = rm >> $urandom_range(0, 22);
      if ($urandom_range(0, 15) == 0) rm = '0;
      rb = {1'($urandom), 8'($urandom), rm};
      run_op(ra, rb, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
